// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if
//   Groups the two handshakes around the prefetch stage:
//   - instruction bus (split address/data, SRAM-like):
//       inst_req, inst_addr          : request valid / address   (IFU -> memory)
//       inst_addr_ok                 : request accepted           (memory -> IFU)
//       inst_data_ok, inst_rdata     : in-order response + data   (memory -> IFU)
//   - ID handoff (valid/allowin):
//       id_valid, id_inst, id_pc,
//       id_ex_adef                   : head queue entry           (IFU -> ID)
//       id_allowin                   : ID accepts the head entry  (ID -> IFU)
//   modport master is the fetch unit, modport slave is its environment.
interface ifu_prefetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        id_allowin;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ex_adef;

    modport master (
        output inst_req, inst_addr, id_valid, id_inst, id_pc, id_ex_adef,
        input  inst_addr_ok, inst_data_ok, inst_rdata, id_allowin
    );

    modport slave (
        input  inst_req, inst_addr, id_valid, id_inst, id_pc, id_ex_adef,
        output inst_addr_ok, inst_data_ok, inst_rdata, id_allowin
    );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch
//   Instruction prefetch stage. Issues reads on the split-handshake
//   instruction bus, keeps up to DEPTH fetches outstanding and holds results
//   in an in-order circular queue whose head is offered to ID.
//   Redirects (flush has priority over br_taken) empty the queue and turn
//   every still-outstanding response into one to be silently dropped.
//   A misaligned fetch PC produces a filled ADEF entry instead of a request
//   and halts fetch until the next redirect.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   DEPTH        queue entries and in-flight bound (power of two, >= 2)
// Ports
//   clk, resetn  clock, asynchronous active-low reset
//   flush        WB redirect, target flush_target
//   br_taken     branch redirect, target br_target
//   bus          ifu_prefetch_if.master (instruction bus + ID handoff)
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [31:0]           flush_target,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    ifu_prefetch_if.master        bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      fetch_pc;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW-1:0]    fill_ptr;      // oldest reserved entry still waiting for data
    logic [CW-1:0]    count;         // reserved entries (filled or not)
    logic [CW-1:0]    pend_cnt;      // live requests whose data has not returned
    logic [CW-1:0]    discard_cnt;   // stale responses still to be dropped
    logic             halt;
    logic             run_q;         // low until the first edge after reset
    logic [DEPTH-1:0] q_filled;

    logic [31:0]      q_pc   [DEPTH];
    logic [31:0]      q_inst [DEPTH];
    logic             q_adef [DEPTH];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic        redirect;
    logic [31:0] target;
    logic        has_room;
    logic        slot_free;
    logic        aligned;
    logic        accept;
    logic        adef_take;
    logic        reserve;
    logic        fill;
    logic        drop;
    logic        pop;
    logic        head_valid;

    assign redirect  = flush | br_taken;
    assign target    = flush ? flush_target : br_target;
    assign aligned   = (fetch_pc[1:0] == 2'b00);
    assign slot_free = (count < DEPTH_CNT);
    // Live plus stale outstanding requests may never exceed DEPTH, otherwise
    // a late stale response could land in a freshly reserved entry's slot
    // accounting. count covers the live ones, discard_cnt the stale ones.
    assign has_room  = (({1'b0, count} + {1'b0, discard_cnt}) < DEPTH_SUM);

    assign bus.inst_req  = run_q & ~redirect & ~halt & slot_free & has_room & aligned;
    assign bus.inst_addr = fetch_pc;

    assign accept    = bus.inst_req & bus.inst_addr_ok;
    assign adef_take = run_q & ~redirect & ~halt & slot_free & ~aligned;
    assign reserve   = accept | adef_take;

    assign drop      = bus.inst_data_ok & (discard_cnt != '0);
    assign fill      = bus.inst_data_ok & (discard_cnt == '0) & (pend_cnt != '0) & ~redirect;

    assign head_valid = (count != '0) & q_filled[head];
    assign pop        = head_valid & bus.id_allowin & ~redirect;

    // Outputs come straight from registered queue state; inst_data_ok only
    // reaches them through the q_filled/q_inst registers.
    assign bus.id_valid   = head_valid;
    assign bus.id_pc      = head_valid ? q_pc[head]   : 32'h0;
    assign bus.id_inst    = head_valid ? q_inst[head] : 32'h0;
    assign bus.id_ex_adef = head_valid & q_adef[head];

    // ------------------------------------------------------------------
    // Pointers, counters, flags
    // ------------------------------------------------------------------
    // NOTE: all sequential state is updated with non-blocking assignments so
    // every register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            count       <= '0;
            pend_cnt    <= '0;
            discard_cnt <= '0;
            halt        <= 1'b0;
            run_q       <= 1'b0;
            q_filled    <= '0;
        end else begin
            run_q <= 1'b1;
            if (redirect) begin
                fetch_pc    <= target;
                head        <= tail;
                fill_ptr    <= tail;
                count       <= '0;
                pend_cnt    <= '0;
                halt        <= 1'b0;
                // Every live request becomes stale; a response arriving now
                // is dropped whichever group it belonged to.
                discard_cnt <= discard_cnt + pend_cnt - CW'(bus.inst_data_ok);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (adef_take) begin
                    halt <= 1'b1;
                end
                if (reserve) begin
                    tail           <= tail + AW'(1);
                    q_filled[tail] <= adef_take;
                end
                if (fill) begin
                    q_filled[fill_ptr] <= 1'b1;
                    fill_ptr           <= fill_ptr + AW'(1);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                if (drop) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
                count    <= count + CW'(reserve) - CW'(pop);
                pend_cnt <= pend_cnt + CW'(accept) - CW'(fill);
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue payload
    // ------------------------------------------------------------------
    // NOTE: the payload arrays carry no reset; an entry is only observed once
    // its q_filled bit (which is reset) is set and count covers it, and the
    // ID outputs are forced to zero otherwise.
    always_ff @(posedge clk) begin
        if (reserve) begin
            q_pc[tail]   <= fetch_pc;
            q_inst[tail] <= 32'h0;
            q_adef[tail] <= adef_take;
        end
        if (fill) begin
            q_inst[fill_ptr] <= bus.inst_rdata;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_target = 32'h0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;

    ifu_prefetch_if bus ();

    ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .flush_target (flush_target),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ent_t;

    // Written only by the monitor below; the main process keeps read indices.
    logic [31:0] mem_q [$];
    ent_t        got_q [$];
    int          acc_cnt = 0;

    int mem_rd = 0;
    int got_rd = 0;
    bit rsp_en = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hdead_beef;
    endfunction

    // Handshakes complete at the next posedge; inputs are stable from
    // posedge+1 onwards, so the negedge sees the values the DUT will use.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.inst_req && bus.inst_addr_ok) begin
                mem_q.push_back(bus.inst_addr);
                acc_cnt++;
            end
            if (bus.id_valid && bus.id_allowin && !flush && !br_taken)
                got_q.push_back('{pc: bus.id_pc, inst: bus.id_inst, adef: bus.id_ex_adef});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next posedge and drive this cycle's response.
    task automatic step();
        @(posedge clk);
        #1;
        if (rsp_en && mem_rd < mem_q.size()) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = mem_data(mem_q[mem_rd]);
            mem_rd++;
        end else begin
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = 32'h0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int k;
        k = 0;
        while ((got_q.size() - got_rd) < n && k < budget) begin
            step();
            k++;
        end
        check({name, "_timeout"}, 32'((got_q.size() - got_rd) >= n), 32'd1);
    endtask

    function automatic ent_t got_at(input int i);
        ent_t e;
        e = '{pc: 32'hffff_ffff, inst: 32'hffff_ffff, adef: 1'b1};
        if (got_rd + i < got_q.size()) e = got_q[got_rd + i];
        return e;
    endfunction

    // Redirect scenarios: inputs for the redirect cycle, expected bus state
    // one cycle later, and the expected first entry handed to ID.
    typedef struct {
        string       name;
        logic        fl;
        logic [31:0] ft;
        logic        br;
        logic [31:0] bt;
        logic [31:0] exp_addr;
        logic        exp_req;
        logic [31:0] exp_pc;
        logic        exp_adef;
    } rv_t;

    rv_t vecs [6];

    initial begin
        ent_t e;
        int   base;

        vecs[0] = '{"br",      1'b0, 32'h0,        1'b1, 32'h1c000100, 32'h1c000100, 1'b1, 32'h1c000100, 1'b0};
        vecs[1] = '{"prio",    1'b1, 32'h1c008000, 1'b1, 32'h1c000200, 32'h1c008000, 1'b1, 32'h1c008000, 1'b0};
        vecs[2] = '{"flush",   1'b1, 32'h1c000040, 1'b0, 32'h0,        32'h1c000040, 1'b1, 32'h1c000040, 1'b0};
        vecs[3] = '{"wrap",    1'b0, 32'h0,        1'b1, 32'hfffffffc, 32'hfffffffc, 1'b1, 32'hfffffffc, 1'b0};
        vecs[4] = '{"adef",    1'b0, 32'h0,        1'b1, 32'h1c000102, 32'h1c000102, 1'b0, 32'h1c000102, 1'b1};
        vecs[5] = '{"restart", 1'b1, 32'h1c008000, 1'b0, 32'h0,        32'h1c008000, 1'b1, 32'h1c008000, 1'b0};

        bus.inst_addr_ok = 1'b1;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        bus.id_allowin   = 1'b1;
        rsp_en           = 1'b1;

        // ---------------- reset state ----------------
        #12;
        check("rst_inst_req", 32'(bus.inst_req), 32'd0);
        check("rst_inst_addr", bus.inst_addr, RESET_PC);
        check("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_id_inst", bus.id_inst, 32'h0);
        check("rst_id_adef", 32'(bus.id_ex_adef), 32'd0);

        // ---------------- streaming from reset ----------------
        step();
        resetn = 1'b1;
        steps(2);
        @(negedge clk);
        check("stream_not_yet", 32'(bus.id_valid), 32'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("stream_valid_%0d", i), 32'(bus.id_valid), 32'd1);
            check($sformatf("stream_pc_%0d", i), bus.id_pc, RESET_PC + 32'(4 * i));
            check($sformatf("stream_inst_%0d", i), bus.id_inst, mem_data(RESET_PC + 32'(4 * i)));
            step();
        end

        // ---------------- redirect table ----------------
        foreach (vecs[v]) begin
            steps(3);
            flush        = vecs[v].fl;
            flush_target = vecs[v].ft;
            br_taken     = vecs[v].br;
            br_target    = vecs[v].bt;
            @(negedge clk);
            check({vecs[v].name, "_req_in_redirect"}, 32'(bus.inst_req), 32'd0);
            step();
            flush    = 1'b0;
            br_taken = 1'b0;
            got_rd   = got_q.size();
            @(negedge clk);
            check({vecs[v].name, "_addr"}, bus.inst_addr, vecs[v].exp_addr);
            check({vecs[v].name, "_req"}, 32'(bus.inst_req), 32'(vecs[v].exp_req));
            wait_got(1, 20, vecs[v].name);
            e = got_at(0);
            check({vecs[v].name, "_pc"}, e.pc, vecs[v].exp_pc);
            check({vecs[v].name, "_adef"}, 32'(e.adef), 32'(vecs[v].exp_adef));
            check({vecs[v].name, "_inst"}, e.inst, vecs[v].exp_adef ? 32'h0 : mem_data(vecs[v].exp_pc));
            if (vecs[v].exp_adef) begin
                steps(6);
                @(negedge clk);
                check({vecs[v].name, "_halted_req"}, 32'(bus.inst_req), 32'd0);
                check({vecs[v].name, "_halted_cnt"}, 32'(got_q.size() - got_rd), 32'd1);
            end else begin
                wait_got(2, 10, {vecs[v].name, "_2nd"});
                e = got_at(1);
                check({vecs[v].name, "_pc2"}, e.pc, vecs[v].exp_pc + 32'd4);
                check({vecs[v].name, "_inst2"}, e.inst, mem_data(vecs[v].exp_pc + 32'd4));
            end
        end

        // ---------------- stale responses discarded ----------------
        step();
        bus.inst_addr_ok = 1'b0;
        steps(4);
        flush = 1'b1;
        flush_target = RESET_PC;
        step();
        flush = 1'b0;
        steps(4);
        rsp_en = 1'b0;
        bus.inst_addr_ok = 1'b1;
        base = acc_cnt;
        steps(3);
        bus.inst_addr_ok = 1'b0;
        check("stale_inflight", 32'(acc_cnt - base), 32'd3);
        br_taken  = 1'b1;
        br_target = 32'h1c000100;
        @(negedge clk);
        check("stale_req_in_redirect", 32'(bus.inst_req), 32'd0);
        step();
        br_taken = 1'b0;
        got_rd   = got_q.size();
        bus.inst_addr_ok = 1'b1;
        rsp_en = 1'b1;
        @(negedge clk);
        check("stale_addr", bus.inst_addr, 32'h1c000100);
        wait_got(1, 20, "stale");
        e = got_at(0);
        check("stale_pc", e.pc, 32'h1c000100);
        check("stale_inst", e.inst, mem_data(32'h1c000100));

        // ---------------- backpressure ----------------
        bus.id_allowin = 1'b0;
        flush = 1'b1;
        flush_target = RESET_PC;
        step();
        flush = 1'b0;
        base = acc_cnt;
        steps(12);
        @(negedge clk);
        check("bp_accepts", 32'(acc_cnt - base), 32'(DEPTH));
        check("bp_req_low", 32'(bus.inst_req), 32'd0);
        check("bp_head_valid", 32'(bus.id_valid), 32'd1);
        check("bp_head_pc", bus.id_pc, RESET_PC);
        step();
        bus.id_allowin = 1'b1;
        got_rd = got_q.size();
        wait_got(4, 20, "bp_drain");
        for (int i = 0; i < 4; i++) begin
            e = got_at(i);
            check($sformatf("bp_pc_%0d", i), e.pc, RESET_PC + 32'(4 * i));
            check($sformatf("bp_inst_%0d", i), e.inst, mem_data(RESET_PC + 32'(4 * i)));
        end
        steps(4);
        check("bp_resume", 32'((acc_cnt - base) > DEPTH), 32'd1);

        // ---------------- async reset mid-burst ----------------
        steps(3);
        @(negedge clk);
        check("arst_pre_valid", 32'(bus.id_valid), 32'd1);
        #2;
        resetn = 1'b0;
        bus.inst_data_ok = 1'b0;
        #1;
        check("arst_req", 32'(bus.inst_req), 32'd0);
        check("arst_valid", 32'(bus.id_valid), 32'd0);
        check("arst_addr", bus.inst_addr, RESET_PC);
        mem_rd = mem_q.size();
        step();
        resetn = 1'b1;
        got_rd = got_q.size();
        step();
        @(negedge clk);
        check("arst_restart_addr", bus.inst_addr, RESET_PC);
        check("arst_restart_req", 32'(bus.inst_req), 32'd1);
        wait_got(2, 20, "arst");
        e = got_at(0);
        check("arst_pc0", e.pc, RESET_PC);
        check("arst_inst0", e.inst, mem_data(RESET_PC));
        e = got_at(1);
        check("arst_pc1", e.pc, RESET_PC + 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
